// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back/write-allocate data cache with 4-word lines.
// States: IDLE = serve hits, detect misses | WRITEBACK = flush dirty victim | ALLOCATE = refill line
module dcache_wb_direct #(
  parameter int INDEX_W = 3,
  localparam int TAG_W = 28 - INDEX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [127:0]     r_data [LINES];

  logic [INDEX_W-1:0] w_idx;
  logic [1:0]         w_off;
  logic [TAG_W-1:0]   w_tag;
  logic               w_req;
  logic               w_hit;
  logic [127:0]       w_line;
  logic [31:0]        w_word;
  logic               w_wr_hit;
  logic               w_fill;

  assign w_idx    = proc_addr[INDEX_W+1:2];
  assign w_off    = proc_addr[1:0];
  assign w_tag    = proc_addr[29:INDEX_W+2];
  assign w_req    = proc_read | proc_write;
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_line   = r_data[w_idx];
  assign w_word   = w_line[{w_off, 5'd0} +: 32];
  // A simultaneous read+write is a write.
  assign w_wr_hit = (r_state == S_IDLE) & proc_write & w_hit;
  assign w_fill   = (r_state == S_ALLOCATE) & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (mem_ready) w_next = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, aborting any memory transaction.
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          proc_stall = w_req & ~w_hit;
          if (proc_read && !proc_write && w_hit) proc_rdata = w_word;
        end
        S_WRITEBACK: begin
          proc_stall = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {r_tag[w_idx], w_idx};
          mem_wdata  = w_line;
        end
        S_ALLOCATE: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = proc_addr[29:2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_off, 5'd0} +: 32] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_wb_direct.sv
// Self-checking bench for dcache_wb_direct: directed vector table, reset/spurious-ready
// sequences, and a randomized phase checked against a flat-memory reference model.
module tb_dcache_wb_direct;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  dcache_wb_direct #(.INDEX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Backing memory: blocks written back are stored, others come from a fixed pattern.
  logic [127:0] mem_blk [logic [27:0]];
  logic [31:0]  gold    [logic [29:0]];
  int n_wr = 0, n_rd = 0;
  logic [27:0] last_wb_addr = '0, last_rd_addr = '0;
  logic [31:0] last_wb_w0 = '0;
  int lat_min = 4, lat_max = 4;
  int spur_req = 0;

  function automatic logic [31:0] word_init(input logic [29:0] a);
    logic [127:0] b1;
    b1 = 128'h44443333_22221111_00000000_AAAAAAAA;
    if (a[29:2] == 28'h1) return b1[{a[1:0], 5'd0} +: 32];
    return {2'b00, a} ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] blk_read(input logic [27:0] b);
    logic [127:0] r;
    if (mem_blk.exists(b)) return mem_blk[b];
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = word_init({b, w[1:0]});
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    logic [127:0] b;
    if (gold.exists(a)) return gold[a];
    b = blk_read(a[29:2]);
    return b[{a[1:0], 5'd0} +: 32];
  endfunction

  initial begin : responder
    int cnt, lat, spur_done;
    cnt = 0; lat = 4; spur_done = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (spur_req != spur_done) begin
        spur_done = spur_req;
        mem_ready = 1'b1;
        mem_rdata = {4{32'hBAD0BAD0}};
      end else if (rst_n && (mem_read || mem_write)) begin
        if (cnt == 0) lat = $urandom_range(lat_max, lat_min);
        cnt++;
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (mem_write) begin
            mem_blk[mem_addr] = mem_wdata;
            n_wr++;
            last_wb_addr = mem_addr;
            last_wb_w0 = mem_wdata[31:0];
          end else begin
            mem_rdata = blk_read(mem_addr);
            n_rd++;
            last_rd_addr = mem_addr;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic [1:0] p_op;
    logic [27:0] p_addr;
    logic [127:0] p_wd;
    logic p_end;
    p_op = '0; p_addr = '0; p_wd = '0; p_end = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_op = '0;
      end else begin
        chk("mem_rw_excl", mem_read & mem_write, 0);
        if (!mem_write) chk("wdata_idle", mem_wdata, 0);
        if (!mem_read && !mem_write) chk("addr_idle", mem_addr, 0);
        if (p_op != 2'b00 && !p_end) begin
          chk("op_hold", {mem_write, mem_read}, p_op);
          chk("addr_hold", mem_addr, p_addr);
          chk("wdata_hold", mem_wdata, p_wd);
        end
        p_op = {mem_write, mem_read};
        p_addr = mem_addr;
        p_wd = mem_wdata;
        p_end = mem_ready;
      end
    end
  end

  // Starts just after a rising edge; returns after the request has completed.
  task automatic do_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic first_stall,
                        output int rd_cycles, output logic timeout);
    int cyc;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    @(negedge clk);
    first_stall = proc_stall;
    cyc = 0;
    rd_cycles = 0;
    while (proc_stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mem_read) rd_cycles++;
    end
    rdata = proc_rdata;
    timeout = proc_stall;
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  typedef struct {
    logic rd, wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic stall1;
    int nwr, nrd;
    logic chk_rd;
    logic [31:0] rdata;
    logic [27:0] wb_addr;
    logic [31:0] wb_w0;
    logic [27:0] rd_addr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd,
                              input logic st, input int nw, input int nr, input logic cr,
                              input logic [31:0] rdv, input logic [27:0] wba, input logic [31:0] wbw,
                              input logic [27:0] rda);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.stall1 = st; v.nwr = nw; v.nrd = nr;
    v.chk_rd = cr; v.rdata = rdv; v.wb_addr = wba; v.wb_w0 = wbw; v.rd_addr = rda;
    return v;
  endfunction

  logic mv [8];
  logic md [8];
  logic [24:0] mt [8];

  initial begin : main
    vec_t vecs [12];
    logic [31:0] rdata;
    logic st, to;
    int rc, w0, r0;

    vecs[0]  = mk(1, 0, 30'h5,  0,            1, 0, 1, 1, 32'h00000000,        0,  0,            28'h1);
    vecs[1]  = mk(1, 0, 30'h6,  0,            0, 0, 0, 1, 32'h22221111,        0,  0,            0);
    vecs[2]  = mk(0, 1, 30'h4,  32'hDEADBEEF, 0, 0, 0, 0, 0,                   0,  0,            0);
    vecs[3]  = mk(1, 0, 30'h24, 0,            1, 1, 1, 1, word_init(30'h24),   28'h1, 32'hDEADBEEF, 28'h9);
    vecs[4]  = mk(1, 0, 30'h44, 0,            1, 0, 1, 1, word_init(30'h44),   0,  0,            28'h11);
    vecs[5]  = mk(0, 1, 30'h10, 32'h12345678, 1, 0, 1, 0, 0,                   0,  0,            28'h4);
    vecs[6]  = mk(1, 0, 30'h10, 0,            0, 0, 0, 1, 32'h12345678,        0,  0,            0);
    vecs[7]  = mk(1, 0, 30'h90, 0,            1, 1, 1, 1, word_init(30'h90),   28'h4, 32'h12345678, 28'h24);
    vecs[8]  = mk(1, 0, 30'h10, 0,            1, 0, 1, 1, 32'h12345678,        0,  0,            28'h4);
    vecs[9]  = mk(1, 1, 30'h11, 32'hCAFEF00D, 0, 0, 0, 0, 0,                   0,  0,            0);
    vecs[10] = mk(1, 0, 30'h11, 0,            0, 0, 0, 1, 32'hCAFEF00D,        0,  0,            0);
    vecs[11] = mk(0, 0, 30'h10, 0,            0, 0, 0, 1, 32'h00000000,        0,  0,            0);

    // Reset with a request pending: every output must stay low.
    proc_read = 1'b1; proc_addr = 30'h5;
    repeat (2) @(negedge clk);
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_mem", {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    proc_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      w0 = n_wr; r0 = n_rd;
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, st, rc, to);
      chk($sformatf("v%0d_stall1", i), st, vecs[i].stall1);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_nwr", i), n_wr - w0, vecs[i].nwr);
      chk($sformatf("v%0d_nrd", i), n_rd - r0, vecs[i].nrd);
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      if (vecs[i].nwr > 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wb_addr, vecs[i].wb_addr);
        chk($sformatf("v%0d_wb_w0", i), last_wb_w0, vecs[i].wb_w0);
      end
      if (vecs[i].nrd > 0) chk($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].rd_addr);
      if (i == 0) chk("v0_rd_cycles", rc, 4);
    end

    // mem_ready while idle must not disturb the cache.
    spur_req++;
    repeat (3) @(posedge clk);
    #1;
    r0 = n_rd;
    do_req(1, 0, 30'h11, 0, rdata, st, rc, to);
    chk("spur_stall", st, 0);
    chk("spur_rdata", rdata, 32'hCAFEF00D);
    chk("spur_nrd", n_rd - r0, 0);

    // Reset in the middle of a writeback.
    do_req(0, 1, 30'h8, 32'h0BADCAFE, rdata, st, rc, to);
    lat_min = 20; lat_max = 20;
    proc_read = 1'b1; proc_addr = 30'h28;
    rc = 0;
    do begin
      @(negedge clk);
      rc++;
    end while (!mem_write && rc < 10);
    chk("abort_wb_started", mem_write, 1);
    repeat (2) @(negedge clk);
    w0 = n_wr;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_stall", proc_stall, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    @(negedge clk);
    chk("abort_stall_held", proc_stall, 0);
    proc_read = 1'b0;
    lat_min = 4; lat_max = 4;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    gold.delete();
    r0 = n_rd;
    do_req(1, 0, 30'h8, 0, rdata, st, rc, to);
    chk("post_rst_miss", st, 1);
    chk("post_rst_nwr", n_wr - w0, 0);
    chk("post_rst_nrd", n_rd - r0, 1);
    chk("post_rst_rdata", rdata, word_init(30'h8));

    // Randomized phase from a fresh reset, against the flat-memory model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    gold.delete();
    for (int k = 0; k < 8; k++) begin mv[k] = 1'b0; md[k] = 1'b0; mt[k] = '0; end
    lat_min = 1; lat_max = 5;
    for (int n = 0; n < 400; n++) begin
      logic rd, wr, miss;
      logic [29:0] a;
      logic [31:0] wd;
      logic [2:0] ix;
      int op, ewr;
      logic [27:0] ewb;
      op = $urandom_range(9, 0);
      rd = (op <= 4) || (op == 8);
      wr = (op >= 5) && (op <= 8);
      a  = 30'($urandom_range(127, 0));
      wd = $urandom;
      ix = a[4:2];
      miss = (rd || wr) && !(mv[ix] && mt[ix] == a[29:5]);
      ewr  = (miss && mv[ix] && md[ix]) ? 1 : 0;
      ewb  = {mt[ix], ix};
      w0 = n_wr; r0 = n_rd;
      do_req(rd, wr, a, wd, rdata, st, rc, to);
      chk("rnd_stall1", st, miss);
      chk("rnd_timeout", to, 0);
      chk("rnd_nwr", n_wr - w0, ewr);
      chk("rnd_nrd", n_rd - r0, miss ? 1 : 0);
      if (ewr == 1) chk("rnd_wb_addr", last_wb_addr, ewb);
      if (!wr) chk("rnd_rdata", rdata, rd ? exp_word(a) : 32'd0);
      if (rd || wr) begin
        if (miss) md[ix] = 1'b0;
        mv[ix] = 1'b1;
        mt[ix] = a[29:5];
      end
      if (wr) begin
        md[ix] = 1'b1;
        gold[a] = wd;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
